// File: rtl/rb_arb_if.sv
// rb_arb_if: bundle between the two requesters, the rb_arb arbiter and
// the 16x16 register bank (rb).
//   Requester side : req, rw, rs, wd, lock (in)  gnt, rvalid, ra, rb_o (out)
//   Register bank  : d_in, rw_in, rs_in (out)  a_out, b_out (in)
// Modports: master = requesters + rb model, slave = rb_arb.
interface rb_arb_if #(
   parameter int DW = 16,
   parameter int SW = 12
);
   logic [1:0]      req;
   logic [1:0]      rw;
   logic [2*SW-1:0] rs;
   logic [2*DW-1:0] wd;
   logic [1:0]      lock;
   logic [1:0]      gnt;
   logic [1:0]      rvalid;
   logic [DW-1:0]   ra;
   logic [DW-1:0]   rb_o;
   logic [DW-1:0]   d_in;
   logic            rw_in;
   logic [SW-1:0]   rs_in;
   logic [DW-1:0]   a_out;
   logic [DW-1:0]   b_out;

   modport master (
      output req, rw, rs, wd, lock, a_out, b_out,
      input  gnt, rvalid, ra, rb_o, d_in, rw_in, rs_in
   );

   modport slave (
      input  req, rw, rs, wd, lock, a_out, b_out,
      output gnt, rvalid, ra, rb_o, d_in, rw_in, rs_in
   );
endinterface

// File: rtl/rb_arb.sv
// rb_arb: two-requester round-robin arbiter and 2-stage sequencer in
// front of the rb register bank.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   bus   : rb_arb_if.slave
//           req/rw/rs/wd/lock in per requester, gnt (comb, one-hot),
//           rvalid/ra/rb_o completion, d_in/rw_in/rs_in to rb,
//           a_out/b_out from rb.
// Optional macro RB_ARB_LOCK_EN enables lock-based grant holding,
// bounded by MAX_LOCK consecutive locked accepts.
module rb_arb #(
   parameter int DW       = 16,
   parameter int SW       = 12,
   parameter int MAX_LOCK = 4
) (
   input logic     clk,
   input logic     rst,
   rb_arb_if.slave bus
);

   logic            r_last;
   logic [1:0]      w_rr;
   logic [1:0]      w_arb;
   logic [1:0]      w_gnt;
   logic [1:0]      w_last_oh;
   logic            w_acc;
   logic            w_own;
   logic            w_rw;
   logic [SW-1:0]   w_rs;
   logic [DW-1:0]   w_wd;

   logic            r_s1_v;
   logic            r_s1_own;
   logic            r_rw_in;
   logic [SW-1:0]   r_rs_in;
   logic [DW-1:0]   r_d_in;
   logic [1:0]      r_rvalid;
   logic [DW-1:0]   r_ra;
   logic [DW-1:0]   r_rb;

   assign w_last_oh = r_last ? 2'b10 : 2'b01;

   // Round-robin: on contention, favour the one not granted last.
   always_comb begin
      w_rr = 2'b00;
      unique case (bus.req)
         2'b01:   w_rr = 2'b01;
         2'b10:   w_rr = 2'b10;
         2'b11:   w_rr = r_last ? 2'b01 : 2'b10;
         default: w_rr = 2'b00;
      endcase
   end

`ifdef RB_ARB_LOCK_EN
   localparam logic [3:0] LP_MAX = 4'(MAX_LOCK);

   logic [3:0] r_cnt;
   logic       w_hold;
   logic       w_cap;

   // Locked owner keeps the grant unless it has used up its quota
   // and the other side is waiting.
   assign w_hold = bus.req[r_last] & bus.lock[r_last];
   assign w_cap  = (r_cnt >= LP_MAX) & bus.req[~r_last];
   assign w_arb  = (w_hold & ~w_cap) ? w_last_oh : w_rr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_acc) begin
         if (!bus.lock[w_own])
            r_cnt <= '0;
         else if ((w_own != r_last) || (r_cnt >= LP_MAX))
            r_cnt <= 4'd1;
         else
            r_cnt <= r_cnt + 4'd1;
      end else if (!bus.lock[r_last]) begin
         r_cnt <= '0;
      end
   end
`else
   logic w_unused;
   assign w_unused = ^bus.lock;
   assign w_arb    = w_rr;
`endif

   assign w_gnt = rst ? 2'b00 : w_arb;
   assign w_acc = |(bus.req & w_gnt);
   assign w_own = w_gnt[1];
   assign w_rw  = w_own ? bus.rw[1] : bus.rw[0];
   assign w_rs  = w_own ? bus.rs[2*SW-1:SW] : bus.rs[SW-1:0];
   assign w_wd  = w_own ? bus.wd[2*DW-1:DW] : bus.wd[DW-1:0];

   // Stage 1 drives rb; stage 2 holds rb read data and the ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last   <= 1'b1;
         r_s1_v   <= 1'b0;
         r_s1_own <= 1'b0;
         r_rw_in  <= 1'b0;
         r_rs_in  <= '0;
         r_d_in   <= '0;
         r_rvalid <= 2'b00;
         r_ra     <= '0;
         r_rb     <= '0;
      end else begin
         if (w_acc)
            r_last <= w_own;
         r_s1_v   <= w_acc;
         r_s1_own <= w_own;
         r_rw_in  <= w_acc & w_rw;
         r_rs_in  <= w_acc ? w_rs : '0;
         r_d_in   <= w_acc ? w_wd : '0;
         r_rvalid <= r_s1_v ? (r_s1_own ? 2'b10 : 2'b01) : 2'b00;
         if (r_s1_v) begin
            r_ra <= bus.a_out;
            r_rb <= bus.b_out;
         end
      end
   end

   assign bus.gnt    = w_gnt;
   assign bus.rvalid = r_rvalid;
   assign bus.ra     = r_ra;
   assign bus.rb_o   = r_rb;
   assign bus.d_in   = r_d_in;
   assign bus.rw_in  = r_rw_in;
   assign bus.rs_in  = r_rs_in;

endmodule

// File: tb/tb_rb_arb.sv
// tb_rb_arb: directed bench for rb_arb with a behavioural 16x16 rb
// (synchronous write, combinational A/B read, cleared by rst).
module tb_rb_arb;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   rb_arb_if #(.DW(16), .SW(12)) bus ();

   rb_arb #(.DW(16), .SW(12), .MAX_LOCK(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] regs [16];

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 16; k++) regs[k] <= '0;
      end else if (bus.rw_in) begin
         regs[bus.rs_in[11:8]] <= bus.d_in;
      end
   end

   assign bus.a_out = regs[bus.rs_in[7:4]];
   assign bus.b_out = regs[bus.rs_in[3:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req  = 2'b00;
      bus.rw   = 2'b00;
      bus.lock = 2'b00;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [1:0] exp_g [7];
   logic [1:0] prev_g;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      bus.rs  = '0;
      bus.wd  = '0;
      idle();
      rst = 1'b1;
      tick();
      bus.req = 2'b11;
      #1;
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      tick();
      chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
      chk("rst_ra", 32'(bus.ra), 32'h0);
      chk("rst_rbo", 32'(bus.rb_o), 32'h0);
      chk("rst_din", 32'(bus.d_in), 32'h0);
      chk("rst_rwin", 32'(bus.rw_in), 32'h0);
      chk("rst_rsin", 32'(bus.rs_in), 32'h0);
      idle();
      rst = 1'b0;

      // 1: write then read
      bus.req = 2'b01;
      bus.rw  = 2'b01;
      bus.rs  = {12'h000, 12'h300};
      bus.wd  = {16'h0, 16'h1234};
      #1;
      chk("t1_gnt", 32'(bus.gnt), 32'h1);
      tick();
      chk("t1_rwin", 32'(bus.rw_in), 32'h1);
      chk("t1_rsin", 32'(bus.rs_in), 32'h300);
      chk("t1_din", 32'(bus.d_in), 32'h1234);
      bus.rw = 2'b00;
      bus.rs = {12'h000, 12'h033};
      tick();
      chk("t1_wack", 32'(bus.rvalid), 32'h1);
      chk("t1_wack_ra", 32'(bus.ra), 32'h0);
      chk("t1_rd_rwin", 32'(bus.rw_in), 32'h0);
      idle();
      tick();
      chk("t1_rvalid", 32'(bus.rvalid), 32'h1);
      chk("t1_ra", 32'(bus.ra), 32'h1234);
      chk("t1_rbo", 32'(bus.rb_o), 32'h1234);
      tick();
      chk("t1_rv_end", 32'(bus.rvalid), 32'h0);
      chk("t1_idle_rs", 32'(bus.rs_in), 32'h0);

      // 2: continuous contention alternates from requester 0
      do_reset();
      prev_g = 2'b00;
      bus.rs = {12'h034, 12'h012};
      for (int i = 0; i < 6; i++) begin
         bus.req = 2'b11;
         #1;
         chk("t2_gnt", 32'(bus.gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
         tick();
         chk("t2_rsin", 32'(bus.rs_in), (i % 2 == 0) ? 32'h012 : 32'h034);
         chk("t2_rvalid", 32'(bus.rvalid), 32'(prev_g));
         prev_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      end
      idle();
      tick();
      chk("t2_rv_last", 32'(bus.rvalid), 32'(prev_g));
      tick();
      chk("t2_rv_end", 32'(bus.rvalid), 32'h0);

      // 3: read-after-write, back to back
      bus.req = 2'b01;
      bus.rw  = 2'b01;
      bus.rs  = {12'h000, 12'h500};
      bus.wd  = {16'h0, 16'hBEEF};
      tick();
      bus.rw = 2'b00;
      bus.rs = {12'h000, 12'h056};
      tick();
      chk("t3_wack", 32'(bus.rvalid), 32'h1);
      idle();
      tick();
      chk("t3_rvalid", 32'(bus.rvalid), 32'h1);
      chk("t3_ra", 32'(bus.ra), 32'hBEEF);
      chk("t3_rbo", 32'(bus.rb_o), 32'h0);

      // 4: reset kills an in-flight write
      bus.req = 2'b01;
      bus.rw  = 2'b01;
      bus.rs  = {12'h000, 12'h700};
      bus.wd  = {16'h0, 16'h00FF};
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_rwin", 32'(bus.rw_in), 32'h0);
      chk("t4_rvalid", 32'(bus.rvalid), 32'h0);
      bus.req = 2'b01;
      bus.rs  = {12'h000, 12'h077};
      tick();
      chk("t4_rv_gap", 32'(bus.rvalid), 32'h0);
      idle();
      tick();
      chk("t4_rvalid2", 32'(bus.rvalid), 32'h1);
      chk("t4_ra", 32'(bus.ra), 32'h0);

      // 5: requester 1 withdraws before being granted
      do_reset();
      bus.rs  = {12'h0AB, 12'h011};
      bus.req = 2'b11;
      #1;
      chk("t5_gnt", 32'(bus.gnt), 32'h1);
      bus.req = 2'b01;
      tick();
      chk("t5_rsin", 32'(bus.rs_in), 32'h011);
      idle();
      tick();
      chk("t5_rvalid", 32'(bus.rvalid), 32'h1);
      chk("t5_idle_rs", 32'(bus.rs_in), 32'h0);
      tick();
      chk("t5_rv_end", 32'(bus.rvalid), 32'h0);
      chk("t5_rwin", 32'(bus.rw_in), 32'h0);

      // 6: lock behaviour (or strict alternation without it)
`ifdef RB_ARB_LOCK_EN
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
`else
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
      do_reset();
      bus.rs = {12'h034, 12'h012};
      for (int i = 0; i < 7; i++) begin
         bus.req  = 2'b11;
         bus.lock = 2'b01;
         #1;
         chk("t6_gnt", 32'(bus.gnt), 32'(exp_g[i]));
         tick();
      end
      idle();
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rb_arb.md
Name: rb_arb

Overview:
- Two-requester arbiter and sequencer in front of the 16x16 register bank (rb).
- Accepts read/write requests from requester 0 (CPU datapath) and requester 1 (debug/loader port), and grants one per cycle, round-robin.
- Drives the rb port set (d_in, rw_in, rs_in) from a registered stage, captures rb a_out/b_out, and returns them to the owning requester with a valid pulse.

Parameters:
DW, 16, data width of rb words
SW, 12, register-select width; [11:8] write dest, [7:4] A select, [3:0] B select
MAX_LOCK, 4, max consecutive locked grants (RB_ARB_LOCK_EN only), range 1..15

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  2  request per requester, held until granted
rw  in  2  per requester: 1 = write, 0 = read
rs  in  2*SW  per-requester select, requester i at [i*SW +: SW]
wd  in  2*DW  per-requester write data
lock  in  2  per-requester lock request (used only with RB_ARB_LOCK_EN)
gnt  out  2  one-hot grant, combinational, at most one bit high
rvalid  out  2  one-cycle completion pulse per requester
ra  out  DW  A read data, valid with rvalid
rb_o  out  DW  B read data, valid with rvalid
d_in  out  DW  to rb d_in
rw_in  out  1  to rb rw_in
rs_in  out  SW  to rb rs_in
a_out  in  DW  from rb a_out
b_out  in  DW  from rb b_out

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset:
  - gnt=0, rvalid=0, ra=0, rb_o=0, d_in=0, rw_in=0, rs_in=0.
  - Round-robin pointer favours requester 0; lock counter = 0.
- Handshake: accept when req[i] & gnt[i] at a rising edge. The requester must keep rw/rs/wd stable while req is high and not yet granted.
- Arbitration (combinational gnt):
  - One request: grant it.
  - Both request: grant the requester not granted last.
  - The pointer updates only on an accept.
- Pipeline:
  - Stage 1 (cycle N+1 after accept at edge N): registered d_in/rw_in/rs_in drive rb; rb writes at end of N+1 when rw_in=1.
  - Stage 2 (cycle N+2): a_out/b_out captured at end of N+1 and presented on ra/rb_o; rvalid[owner]=1 for one cycle.
  - Writes also pulse rvalid as an acknowledgement; ra/rb_o then carry A/B of that write's rs (pre-write values).
- Throughput: one accept per cycle, back-to-back, no bubbles.
- Read-after-write: a read accepted one cycle after a write sees the written value (its stage 1 follows the write commit).
- Idle stage 1: rw_in=0, rs_in=0, d_in=0 (reads only, never spurious writes).
- Owner tag travels with each transaction; rvalid is never asserted for the wrong requester.
- Reset mid-operation: in-flight stage 1/2 transactions are discarded with no rvalid; rw_in is forced 0 at the next edge.
- req deasserted while not granted: the request is withdrawn with no side effects.

Optional Feature:
- Macro: RB_ARB_LOCK_EN.
- Defined:
  - If the last-granted requester has req & lock high, it keeps the grant ahead of round-robin.
  - The lock counter increments per locked accept. At MAX_LOCK consecutive locked accepts, the grant is forced to the other requester for one cycle if it is requesting; the counter then resets to 0.
  - The counter clears when lock drops or a grant changes owner.
- Not defined: lock input is ignored and pure round-robin applies; the ports remain present.

Test Plan:
1. Reset, then requester 0 writes rs=0x3_00, wd=0x1234 -> rw_in=1, rs_in=0x300, d_in=0x1234 in N+1; rvalid[0] in N+2. A following read rs=0x033 -> ra=0x1234, rb_o=0x1234 two cycles after its accept.
2. Both requesters request reads continuously for 6 cycles -> gnt alternates 01,10,01,10,01,10 starting with requester 0; rvalid alternates matching, delayed 2 cycles.
3. Write R5=0xBEEF accepted at N, read rs=0x056 accepted at N+1 -> ra=0xBEEF at N+3.
4. rst asserted in the cycle after a write accept to R7=0x00FF -> rw_in=0 after the edge, no rvalid; a later read of R7 returns the rb reset value.
5. requester 1 raises req, then drops it before grant while requester 0 is being serviced -> no rw_in/rs_in activity for requester 1, no rvalid[1].
6. RB_ARB_LOCK_EN, MAX_LOCK=4: requester 0 holds req+lock, requester 1 requests -> gnt[0] for 4 accepts, then gnt[1] for one cycle, then gnt[0] again. Without the macro -> strict alternation.
